// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: receive side of a 4-slot TDM link. Hunts for frame_sync,
// then assembles four MSB-first WIDTH-bit slots into channel words y0..y3,
// each announced by a one-cycle vld strobe. A frame_sync seen mid-frame
// restarts reception at slot 0 and raises sync_err.
module tdm_demux_1x4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       vld,
    output logic             frame_done,
    output logic             sync_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]             slot_cnt_q, slot_cnt_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [3:0][WIDTH-1:0]  y_q, y_d;
    logic [3:0]             vld_q, vld_d;
    logic                   frame_done_q, frame_done_d;
    logic                   sync_err_q, sync_err_d;

    // Word as it stands once the current bit is shifted in (LSB position).
    logic [WIDTH-1:0]       word_in;
    assign word_in = {shift_q[WIDTH-2:0], din};

    // Next-state logic: hunt for sync, shift bits, complete slots, resync.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        shift_d      = shift_q;
        y_d          = y_q;
        vld_d        = 4'b0000;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            if (frame_sync) begin
                // Sync always (re)starts slot 0; in RECV the partial slot is dropped.
                if (state_q == ST_RECV) begin
                    sync_err_d = 1'b1;
                end
                state_d    = ST_RECV;
                shift_d    = {{(WIDTH-1){1'b0}}, din};
                bit_cnt_d  = CNT_W'(1);
                slot_cnt_d = 2'd0;
            end else if (state_q == ST_RECV) begin
                shift_d = word_in;
                if (bit_cnt_q == LAST_BIT) begin
                    y_d[slot_cnt_q]   = word_in;
                    vld_d[slot_cnt_q] = 1'b1;
                    bit_cnt_d         = '0;
                    slot_cnt_d        = slot_cnt_q + 2'd1;
                    if (slot_cnt_q == 2'd3) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_HUNT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State and output registers; channel words are cleared by reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            bit_cnt_q    <= '0;
            slot_cnt_q   <= 2'd0;
            shift_q      <= '0;
            y_q          <= '0;
            vld_q        <= 4'b0000;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            shift_q      <= shift_d;
            y_q          <= y_d;
            vld_q        <= vld_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign y0         = y_q[0];
    assign y1         = y_q[1];
    assign y2         = y_q[2];
    assign y3         = y_q[3];
    assign vld        = vld_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign busy       = (state_q == ST_RECV);

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Testbench for tdm_demux_1x4 (WIDTH = 8). The driver pushes the expected
// output event (cycle, vld, word, frame_done, sync_err) onto a scoreboard
// whenever it drives a slot LSB or a misaligned sync; the monitor pops and
// compares whenever the DUT raises any pulse output.
module tb_tdm_demux_1x4;

    localparam int WIDTH = 8;

    typedef struct {
        int          cyc;
        logic [3:0]  vld;
        int          chan;
        logic [7:0]  word;
        logic        fd;
        logic        se;
        logic [31:0] yall;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic [3:0]       vld;
    logic             frame_done;
    logic             sync_err;
    logic             busy;

    int   n_checks;
    int   n_pass;
    int   cyc;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] exp_y [4];

    tdm_demux_1x4 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .vld        (vld),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected events.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] ysel(input int chan);
        case (chan)
            0:       return y0;
            1:       return y1;
            2:       return y2;
            default: return y3;
        endcase
    endfunction

    // Monitor: every pulse on the outputs must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (vld != 4'b0000 || frame_done || sync_err)) begin
            if (sb.size() == 0) begin
                check("spurious_evt", {58'd0, vld, frame_done, sync_err}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("evt_cycle", cyc, mon_e.cyc);
                check("vld", vld, mon_e.vld);
                check("frame_done", frame_done, mon_e.fd);
                check("sync_err", sync_err, mon_e.se);
                if (mon_e.se) check("held_words", {y3, y2, y1, y0}, mon_e.yall);
                else          check("word", ysel(mon_e.chan), mon_e.word);
            end
        end
    end

    task automatic drive_bit(input logic b, input logic fs);
        @(negedge clk);
        din        = b;
        frame_sync = fs;
        din_valid  = 1'b1;
    endtask

    // Idle cycles carry garbage, including frame_sync, which must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid  = 1'b0;
            din        = 1'($urandom);
            frame_sync = 1'($urandom);
        end
    endtask

    task automatic push_word(input int chan, input logic [7:0] w);
        exp_t e;
        e.cyc  = cyc + 1;
        e.vld  = 4'b0001 << chan;
        e.chan = chan;
        e.word = w;
        e.fd   = (chan == 3);
        e.se   = 1'b0;
        e.yall = '0;
        sb.push_back(e);
        exp_y[chan] = w;
    endtask

    task automatic push_serr();
        exp_t e;
        e.cyc  = cyc + 1;
        e.vld  = 4'b0000;
        e.chan = 0;
        e.word = '0;
        e.fd   = 1'b0;
        e.se   = 1'b1;
        e.yall = {exp_y[3], exp_y[2], exp_y[1], exp_y[0]};
        sb.push_back(e);
    endtask

    task automatic send_slot(input logic [7:0] w, input int chan, input bit sync_first,
                             input bit serr, input int stall_at, input int stall_len);
        for (int i = 7; i >= 0; i--) begin
            if (i == stall_at) idle(stall_len);
            drive_bit(w[i], sync_first && (i == 7));
            if (serr && i == 7) push_serr();
            if (i == 0) push_word(chan, w);
        end
    endtask

    task automatic send_frame(input logic [31:0] words, input bit serr);
        send_slot(words[31:24], 0, 1'b1, serr, -1, 0);
        send_slot(words[23:16], 1, 1'b0, 1'b0, -1, 0);
        send_slot(words[15:8],  2, 1'b0, 1'b0, -1, 0);
        send_slot(words[7:0],   3, 1'b0, 1'b0, -1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] w2;
        n_checks   = 0;
        n_pass     = 0;
        cyc        = 0;
        for (int i = 0; i < 4; i++) exp_y[i] = 8'h00;
        rst_n      = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_y", {y3, y2, y1, y0}, 32'h0);
        check("rst_pulses", {vld, frame_done, sync_err}, 6'd0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Basic frame.
        send_frame(32'hA5_3C_0F_F0, 1'b0);
        idle(3);
        check("basic_busy_after", busy, 1'b0);

        // Stalls: 3 idle cycles inside slot 1, 1 idle cycle before slot 3.
        send_slot(8'hA5, 0, 1'b1, 1'b0, -1, 0);
        send_slot(8'h3C, 1, 1'b0, 1'b0, 4, 3);
        send_slot(8'h0F, 2, 1'b0, 1'b0, -1, 0);
        send_slot(8'hF0, 3, 1'b0, 1'b0, 7, 1);
        idle(3);
        check("stall_busy_after", busy, 1'b0);

        // Hunt discard: unsynced bits first.
        for (int i = 0; i < 10; i++) drive_bit(1'($urandom), 1'b0);
        idle(1);
        check("hunt_busy", busy, 1'b0);
        send_frame(32'h11_22_33_44, 1'b0);
        idle(3);

        // Misaligned sync after 5 bits of slot 2.
        send_slot(8'h01, 0, 1'b1, 1'b0, -1, 0);
        send_slot(8'h02, 1, 1'b0, 1'b0, -1, 0);
        w2 = 8'h03;
        for (int i = 7; i >= 3; i--) drive_bit(w2[i], 1'b0);
        send_frame(32'h55_66_77_88, 1'b1);
        idle(3);

        // Reset in the middle of slot 1.
        send_slot(8'hC3, 0, 1'b1, 1'b0, -1, 0);
        w2 = 8'h5A;
        for (int i = 7; i >= 5; i--) drive_bit(w2[i], 1'b0);
        @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midrst_y", {y3, y2, y1, y0}, 32'h0);
        check("midrst_pulses", {vld, frame_done, sync_err}, 6'd0);
        check("midrst_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) exp_y[i] = 8'h00;
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) drive_bit(1'($urandom), 1'b0);
        idle(1);
        check("postrst_busy", busy, 1'b0);
        check("postrst_y", {y3, y2, y1, y0}, 32'h0);
        send_frame(32'hDE_AD_BE_EF, 1'b0);
        idle(3);

        // Back-to-back frames: second sync right after the slot-3 LSB.
        send_frame(32'h12_34_56_78, 1'b0);
        send_frame(32'h9A_BC_DE_F0, 1'b0);
        idle(4);

        check("final_y", {y3, y2, y1, y0}, {exp_y[3], exp_y[2], exp_y[1], exp_y[0]});
        check("sb_empty", sb.size(), 0);
        check("final_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive-side counterpart of the 4-channel TDM multiplexer: splits one serial stream into four parallel channel words.
- Input is a framed serial stream of 4 slots, each WIDTH bits, MSB first. Slot 0 is flagged by frame_sync.
- Each completed slot is registered onto its channel output with a one-cycle valid strobe.
- Sits between the serial link and the four per-channel consumers.

Parameters:
WIDTH, 8, bits per slot (channel word width); legal range 2..32

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
din  input  1  serial data bit
din_valid  input  1  din/frame_sync are sampled only when high
frame_sync  input  1  high with the first (MSB) bit of slot 0
y0  output  WIDTH  channel 0 word
y1  output  WIDTH  channel 1 word
y2  output  WIDTH  channel 2 word
y3  output  WIDTH  channel 3 word
vld  output  4  vld[k] pulses 1 cycle when yk updates
frame_done  output  1  1-cycle pulse with vld[3]
sync_err  output  1  1-cycle pulse on unexpected frame_sync
busy  output  1  high while in RECV

Behaviour:
- Reset, asynchronous on rst_n low:
  - y0..y3 = 0, vld = 0, frame_done = 0, sync_err = 0, busy = 0.
  - State = HUNT; bit_cnt = 0, slot_cnt = 0, shift register = 0.
- Accepted bit: rising edge with din_valid = 1. With din_valid = 0 nothing advances, and outputs other than the pulses hold. The pulse outputs are low in any cycle without a completing event.
- HUNT:
  - Accepted bit with frame_sync = 0 is discarded.
  - Accepted bit with frame_sync = 1 is stored as the MSB of slot 0; bit_cnt = 1, slot_cnt = 0, go to RECV.
  - frame_sync with din_valid = 0 is ignored.
- RECV:
  - Each accepted bit shifts in MSB first and bit_cnt increments.
  - When bit_cnt reaches WIDTH-1 and a bit is accepted, the slot is complete:
    - The assembled word is registered into y[slot_cnt] on that same edge.
    - vld[slot_cnt] is high for the following cycle.
    - bit_cnt wraps to 0 and slot_cnt increments.
  - Latency: the word appears on yk, with vld[k] = 1, in the cycle immediately after the edge that accepts its LSB.
  - Completion of slot 3: frame_done pulses together with vld[3], slot_cnt wraps to 0, state returns to HUNT. Every frame requires its own frame_sync.
- Resync: an accepted bit with frame_sync = 1 while in RECV (any bit_cnt/slot_cnt) is a misaligned sync.
  - sync_err pulses the next cycle.
  - The partial slot is discarded; no vld for it.
  - Slots already completed in this frame keep their output values.
  - That bit becomes the MSB of slot 0 (bit_cnt = 1, slot_cnt = 0, stay in RECV).
- Outputs yk hold their last value until that channel's slot next completes.
- At most one vld bit is high in any cycle.
- busy = 1 exactly while the state is RECV.
- Reset asserted mid-frame: all state is cleared immediately. After rst_n rises, the block needs a new frame_sync.
- Only vld and frame_done qualify the outputs. No backpressure: consumers must take a word within the cycle vld is high.

Test Plan (WIDTH = 8):
- Basic frame: frame_sync with the first bit, then 32 continuously valid bits A5,3C,0F,F0 MSB first → y0=A5 (vld=0001), y1=3C (0010), y2=0F (0100), y3=F0 (1000) plus frame_done, each one cycle after the edge accepting that slot's LSB; busy low afterwards.
- Stalls: same frame with din_valid low for 3 cycles inside slot 1 and 1 cycle between slots 2 and 3 → identical words; vld pulses delayed by exactly the stalled cycles; no spurious pulses.
- Hunt discard: 10 valid bits without frame_sync, then a synced frame 11,22,33,44 → only 11,22,33,44 are output; nothing happens before the sync.
- Misaligned sync: frame_sync after 5 bits of slot 2 in a frame carrying 01,02,… → sync_err pulse; y0=01, y1=02 retained; no vld[2]. The new frame 55,66,77,88 then outputs correctly.
- Reset mid-frame: rst_n low during slot 1 → all outputs 0 immediately. After release, unsynced bits are ignored; a synced frame DE,AD,BE,EF is received correctly.
- Back-to-back frames: frame_sync on the bit immediately following the slot-3 LSB of the previous frame → both frames decoded; no sync_err; frame_done pulses exactly once per frame.
